// File: rtl/io_serial_tx_device.sv
// IO-bus UART transmitter: bytes written to DATA_ID queue in a small FIFO and shift out as 8N1 on tx.
// Define IO_SERIAL_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module io_serial_tx_device #(
    parameter logic [7:0]  DATA_ID      = 8'd2,
    parameter logic [7:0]  STATUS_ID    = 8'd3,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_AW      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  device_id,
    input  logic [31:0] value_in,
    input  logic        is_write,
    output logic [31:0] value_out,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned NW    = FIFO_AW + 1;
    localparam int unsigned CW    = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]      count_q;
    logic               overflow_q;

    logic empty_c, full_c, push_c, drop_c, clear_c, pop_c;

    state_t        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          tx_d, busy_d;
    logic          bit_end_c;
    logic [2:0]    bit_nxt_c;

    // Upper write-data bits are architecturally ignored.
    logic unused_value_bits;
    assign unused_value_bits = ^value_in[31:8];

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == NW'(DEPTH));
    assign push_c  = is_write && (device_id == DATA_ID) && !full_c;
    assign drop_c  = is_write && (device_id == DATA_ID) && full_c;
    assign clear_c = is_write && (device_id == STATUS_ID);

    // FIFO bookkeeping; full is judged on the pre-edge count so a same-edge pop cannot make room.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + NW'(1);
                2'b01:   count_q <= count_q - NW'(1);
                default: count_q <= count_q;
            endcase
            if (drop_c)       overflow_q <= 1'b1;
            else if (clear_c) overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr_q] <= value_in[7:0];
    end

    // Transmit FSM state and registered line outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            tx        <= tx_d;
            busy      <= busy_d;
        end
    end

    // Next-state logic; tx_d is the line level for the cycle after the edge.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        tx_d      = tx;
        busy_d    = busy;
        pop_c     = 1'b0;
        bit_end_c = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
        bit_nxt_c = bit_cnt_q + 3'd1;

        case (state_q)
            IDLE: begin
                if (!empty_c) begin
                    pop_c     = 1'b1;
                    data_d    = mem[rd_ptr_q];
                    state_d   = START;
                    clk_cnt_d = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_d   = DATA;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    tx_d      = data_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
`ifdef IO_SERIAL_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^data_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_nxt_c;
                        tx_d      = data_q[bit_nxt_c];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
`ifdef IO_SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_end_c) begin
                    state_d   = STOP;
                    clk_cnt_d = '0;
                    tx_d      = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end_c) begin
                    state_d   = IDLE;
                    clk_cnt_d = '0;
                    tx_d      = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Combinational read port.
    always_comb begin
        value_out = '0;
        if (device_id == STATUS_ID) begin
            value_out = {24'b0, 4'(count_q), overflow_q, full_c, empty_c, busy};
        end
    end

endmodule

// File: tb/tb_io_serial_tx_device.sv
// Self-checking bench for io_serial_tx_device: reset-state table, directed frame/overflow/reset
// sequences, then random bus traffic compared each cycle against a queue-based frame model.
module tb_io_serial_tx_device;

    localparam int unsigned C     = 4;
    localparam int unsigned DEPTH = 4;
`ifdef IO_SERIAL_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FL = NBITS * C;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  device_id;
    logic [31:0] value_in;
    logic        is_write;
    logic [31:0] value_out;
    logic        tx;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_serial_tx_device dut (
        .clk       (clk),
        .reset     (reset),
        .device_id (device_id),
        .value_in  (value_in),
        .is_write  (is_write),
        .value_out (value_out),
        .tx        (tx),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0]  id;
        logic [31:0] exp_value;
        logic        exp_tx;
        logic        exp_busy;
    } vec_t;

    // Reference model state.
    logic [7:0] q[$];
    bit         m_ov;
    bit         m_in_frame;
    int         m_pos;
    logic [7:0] m_cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [7:0] id, input logic [31:0] v);
        is_write  = w;
        device_id = id;
        value_in  = v;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef IO_SERIAL_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] id);
        if (id != 8'd3) return 32'h0;
        return {24'b0, 4'(q.size()), m_ov, q.size() == DEPTH, q.size() == 0, m_in_frame};
    endfunction

    function automatic void model_edge(input logic r, input logic w, input logic [7:0] id,
                                       input logic [31:0] v);
        bit full_pre, pop_ok;
        if (r) begin
            q.delete();
            m_ov = 0; m_in_frame = 0; m_pos = 0;
            return;
        end
        full_pre = (q.size() == DEPTH);
        pop_ok   = !m_in_frame && (q.size() != 0);
        if (m_in_frame) begin
            m_pos++;
            if (m_pos == FL) m_in_frame = 0;
        end
        if (pop_ok) begin
            m_cur = q.pop_front();
            m_in_frame = 1;
            m_pos = 0;
        end
        if (w && id == 8'd2) begin
            if (full_pre) m_ov = 1;
            else q.push_back(v[7:0]);
        end else if (w && id == 8'd3) begin
            m_ov = 0;
        end
    endfunction

    // Write one byte into an idle device and follow its frame bit by bit.
    task automatic send_and_check(input logic [7:0] b);
        drive(1'b1, 8'd2, {24'hFFFFFF, b});
        tick;
        drive(1'b0, 8'd3, 32'h0);
        #1;
        chk("queued_status", value_out, 32'h00000010);
        chk("queued_tx", {31'b0, tx}, 32'd1);
        for (int k = 0; k < int'(FL); k++) begin
            tick;
            chk("frame_tx", {31'b0, tx}, {31'b0, frame_bit(b, k / int'(C))});
            chk("frame_busy", {31'b0, busy}, 32'd1);
        end
        tick;
        chk("end_tx", {31'b0, tx}, 32'd1);
        chk("end_busy", {31'b0, busy}, 32'd0);
        chk("end_status", value_out, 32'h00000002);
    endtask

    initial begin
        vec_t vecs[5];
        bit   burst;
        logic r, w;
        logic [7:0]  id;
        logic [31:0] v;

        vecs[0] = '{8'd3,   32'h00000002, 1'b1, 1'b0};
        vecs[1] = '{8'd2,   32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{8'd7,   32'h00000000, 1'b1, 1'b0};
        vecs[3] = '{8'd0,   32'h00000000, 1'b1, 1'b0};
        vecs[4] = '{8'd255, 32'h00000000, 1'b1, 1'b0};

        reset = 1'b1;
        drive(1'b0, 8'd3, 32'h0);
        tick;
        tick;
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].id, 32'h0);
            #1;
            chk("reset_read", value_out, vecs[i].exp_value);
            chk("reset_tx", {31'b0, tx}, {31'b0, vecs[i].exp_tx});
            chk("reset_busy", {31'b0, busy}, {31'b0, vecs[i].exp_busy});
        end

        send_and_check(8'hA5);
        send_and_check(8'h07);

        // Fill the FIFO behind a running frame.
        drive(1'b1, 8'd2, 32'h11);
        tick;
        drive(1'b0, 8'd3, 32'h0);
        tick;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'd2, 32'h20 + i);
            tick;
        end
        drive(1'b0, 8'd3, 32'h0);
        #1;
        chk("overflow_status", value_out, 32'h0000004D);
        drive(1'b1, 8'd3, 32'hDEAD);
        tick;
        drive(1'b0, 8'd3, 32'h0);
        #1;
        chk("cleared_status", value_out, 32'h00000045);
        drive(1'b0, 8'd7, 32'h0);
        #1;
        chk("other_id_read", value_out, 32'h0);

        // Reset while shifting data bits.
        drive(1'b0, 8'd3, 32'h0);
        repeat (10) tick;
        chk("mid_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("abort_tx", {31'b0, tx}, 32'd1);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_status", value_out, 32'h00000002);
        repeat (3) tick;
        chk("discard_busy", {31'b0, busy}, 32'd0);

        // Random traffic against the model.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        model_edge(1'b1, 1'b0, 8'd0, 32'h0);
        burst = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (cyc % 300 == 0) burst = ~burst;
            r = ($urandom_range(0, 399) == 0);
            w = burst ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 3))
                0, 1:    id = 8'd2;
                2:       id = 8'd3;
                default: id = 8'($urandom);
            endcase
            v = $urandom;
            reset = r;
            drive(w, id, v);
            #1;
            chk("rand_read", value_out, model_read(id));
            chk("rand_tx", {31'b0, tx},
                {31'b0, m_in_frame ? frame_bit(m_cur, m_pos / int'(C)) : 1'b1});
            chk("rand_busy", {31'b0, busy}, {31'b0, m_in_frame});
            @(posedge clk);
            model_edge(r, w, id, v);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
